regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the 16x16 register file between the CPU core and a host/debug port.
//  Core has priority; host reg read/write requests wait, with bounded starvation.
//  Sits between the core, the host bridge and the regfile, muxing its
//  rSrc/rDst/write/write_data/pc inputs.
//  Regfile writes on negedge clk; r0 reads as 0; a write to r15 stores pc.
// PARAMETERS
//  DATAWIDTH     16  register data width
//  REGWIDTH      4   register address width
//  STARVE_LIMIT  7   max WAIT cycles host defers to core (0..255, 8-bit counter)
// PORTS
//  clk          in   1          system clock, posedge logic
//  reset        in   1          synchronous, active-high
//  core_valid   in   1          core uses regfile this cycle
//  core_write   in   1          core write-back enable
//  core_rsrc    in   REGWIDTH   core src reg
//  core_rdst    in   REGWIDTH   core dst reg
//  core_wdata   in   DATAWIDTH  core write-back data
//  core_pc      in   DATAWIDTH  core pc (r15 link value)
//  core_stall   out  1          core must hold all inputs this cycle
//  core_dsrc    out  DATAWIDTH  src data to core
//  core_ddst    out  DATAWIDTH  dst data to core
//  host_req     in   1          host request, 4-phase level
//  host_we      in   1          1=write, 0=read
//  host_addr    in   REGWIDTH   host target reg
//  host_wdata   in   DATAWIDTH  host write data
//  host_ack     out  1          request complete, held until host_req=0
//  host_rdata   out  DATAWIDTH  reg value, valid while host_ack=1
//  rf_write, rf_rsrc, rf_rdst, rf_wdata, rf_pc   out   to regfile
//  rf_dsrc, rf_ddst                             in    from regfile
// BEHAVIOUR
//  Reset: state=IDLE, wait_cnt=0, host_ack=0, host_rdata=0, host_*_q=0.
//  rf_write=0 whenever reset=1, combinationally.
//  FSM (posedge):
//   IDLE:   host_req=1 -> capture host_we/addr/wdata into *_q; go WAIT.
//   WAIT:   core_valid=1 and wait_cnt<STARVE_LIMIT -> wait_cnt++.
//           Otherwise -> ACCESS, wait_cnt=0.
//   ACCESS: one cycle; host_rdata<=rf_ddst; -> DONE.
//   DONE:   host_ack=1; host_req=0 -> IDLE, ack drops next cycle.
//  Host inputs are ignored outside IDLE. A new request needs host_req low,
//  then high again.
//  Mux, combinational:
//   state!=ACCESS: rf_* follow core_*; rf_write=core_valid&core_write.
//                  core_dsrc/ddst = rf_dsrc/ddst; core_stall=0.
//   state==ACCESS: rf_rsrc=rf_rdst=addr_q; rf_wdata=rf_pc=wdata_q
//                  (so a host write to r15 stores host data);
//                  rf_write=we_q; core_stall=1; core_dsrc=core_ddst=0.
//  Read data: a read returns the reg value. A write returns the written value,
//  or 0 for r0, since the negedge write lands before the posedge capture.
//  Latency, core idle: req seen at edge k -> ACCESS in cycle k+2 -> ack from k+3.
//  Worst case: WAIT lasts STARVE_LIMIT+1 cycles. core_stall is never high more
//  than 1 cycle per host request.
//  A core write in WAIT/IDLE/DONE proceeds normally; the host sees it if later.
//  Reset mid-op: no regfile write in the reset cycle; next state IDLE; no ack.
// TESTING
//  1 core_valid=0; host write r3=0xBEEF -> ACCESS: rf_write=1, rf_rdst=3,
//    rf_wdata=0xBEEF, core_stall=1 for 1 cycle; ack. Host read r3 -> 0xBEEF.
//  2 host write r15=0x1234 -> rf_pc=0x1234 in ACCESS; host read r15 -> 0x1234.
//  3 host write r0=0xFFFF then read r0 -> host_rdata=0x0000 both times.
//  4 core_valid held 1, STARVE_LIMIT=7 -> exactly 8 WAIT cycles, then
//    1 ACCESS with core_stall=1; core writes pass in all other cycles.
//  5 core writes r5=0xAAAA while host in WAIT; host read r5 -> 0xAAAA.
//  6 reset=1 in ACCESS of host write r4=0x5555 -> rf_write=0, r4 unchanged,
//    IDLE next, host_ack stays 0; host_req held high restarts the transaction.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the register file between the core and a host port, core first with bounded host starvation
module regfile_port_arbiter #(
  parameter int DATAWIDTH    = 16,
  parameter int REGWIDTH     = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_valid,
  input  logic                 core_write,
  input  logic [REGWIDTH-1:0]  core_rsrc,
  input  logic [REGWIDTH-1:0]  core_rdst,
  input  logic [DATAWIDTH-1:0] core_wdata,
  input  logic [DATAWIDTH-1:0] core_pc,
  output logic                 core_stall,
  output logic [DATAWIDTH-1:0] core_dsrc,
  output logic [DATAWIDTH-1:0] core_ddst,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [REGWIDTH-1:0]  host_addr,
  input  logic [DATAWIDTH-1:0] host_wdata,
  output logic                 host_ack,
  output logic [DATAWIDTH-1:0] host_rdata,
  output logic                 rf_write,
  output logic [REGWIDTH-1:0]  rf_rsrc,
  output logic [REGWIDTH-1:0]  rf_rdst,
  output logic [DATAWIDTH-1:0] rf_wdata,
  output logic [DATAWIDTH-1:0] rf_pc,
  input  logic [DATAWIDTH-1:0] rf_dsrc,
  input  logic [DATAWIDTH-1:0] rf_ddst
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  state_t               state, state_n;
  logic [7:0]           wait_cnt, wait_cnt_n;
  logic                 we_q, acc;
  logic [REGWIDTH-1:0]  addr_q;
  logic [DATAWIDTH-1:0] wdata_q;
  assign acc = state == ACCESS;
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      host_rdata <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (state == IDLE && host_req) begin
        we_q    <= host_we;
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
      end
      if (acc) host_rdata <= rf_ddst;
    end
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      IDLE:    state_n = host_req ? WAIT : IDLE;
      WAIT:
        if (core_valid && wait_cnt < LIMIT) wait_cnt_n = wait_cnt + 8'd1;
        else begin
          state_n    = ACCESS;
          wait_cnt_n = '0;
        end
      ACCESS:  state_n = DONE;
      default: state_n = host_req ? DONE : IDLE;
    endcase
  end
  // host data doubles as pc so a host write to r15 stores host data
  assign host_ack   = state == DONE;
  assign core_stall = acc;
  assign rf_write   = !reset && (acc ? we_q : core_valid && core_write);
  assign rf_rsrc    = acc ? addr_q : core_rsrc;
  assign rf_rdst    = acc ? addr_q : core_rdst;
  assign rf_wdata   = acc ? wdata_q : core_wdata;
  assign rf_pc      = acc ? wdata_q : core_pc;
  assign core_dsrc  = acc ? '0 : rf_dsrc;
  assign core_ddst  = acc ? '0 : rf_ddst;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed checks of the core/host regfile arbiter against a behavioural regfile
module tb_regfile_port_arbiter;
  logic        clk = 1'b0, reset;
  logic        core_valid, core_write, core_stall;
  logic [3:0]  core_rsrc, core_rdst;
  logic [15:0] core_wdata, core_pc, core_dsrc, core_ddst;
  logic        host_req, host_we, host_ack;
  logic [3:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        rf_write;
  logic [3:0]  rf_rsrc, rf_rdst;
  logic [15:0] rf_wdata, rf_pc, rf_dsrc, rf_ddst;
  logic [15:0] regs [16] = '{default: 16'h0};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_write(core_write), .core_rsrc(core_rsrc), .core_rdst(core_rdst),
    .core_wdata(core_wdata), .core_pc(core_pc), .core_stall(core_stall), .core_dsrc(core_dsrc),
    .core_ddst(core_ddst), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata), .rf_write(rf_write),
    .rf_rsrc(rf_rsrc), .rf_rdst(rf_rdst), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
    .rf_dsrc(rf_dsrc), .rf_ddst(rf_ddst)
  );

  // regfile: negedge write, r15 takes pc, r0 reads zero
  always @(negedge clk) if (rf_write) regs[rf_rdst] <= rf_rdst == 4'd15 ? rf_pc : rf_wdata;
  assign rf_dsrc = rf_rsrc == 4'd0 ? 16'h0 : regs[rf_rsrc];
  assign rf_ddst = rf_rdst == 4'd0 ? 16'h0 : regs[rf_rdst];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_op(input logic we, input logic [3:0] addr, input logic [15:0] wd,
                         input int exp_lat, input logic [15:0] exp_rd, input string tag);
    int lat = 0, bad = 0;
    host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    do begin
      tick();
      lat++;
      if (!core_stall && rf_write !== (core_valid & core_write)) bad++;
    end while (!core_stall && lat < 40);
    chk($sformatf("%s_latency", tag), 16'(lat), 16'(exp_lat));
    chk($sformatf("%s_core_pass", tag), 16'(bad), 16'd0);
    chk($sformatf("%s_rf_write", tag), 16'(rf_write), 16'(we));
    chk($sformatf("%s_rf_rdst", tag), 16'(rf_rdst), 16'(addr));
    chk($sformatf("%s_rf_rsrc", tag), 16'(rf_rsrc), 16'(addr));
    chk($sformatf("%s_rf_wdata", tag), rf_wdata, wd);
    chk($sformatf("%s_rf_pc", tag), rf_pc, wd);
    chk($sformatf("%s_core_dsrc", tag), core_dsrc, 16'h0);
    chk($sformatf("%s_core_ddst", tag), core_ddst, 16'h0);
    tick();
    chk($sformatf("%s_stall_once", tag), 16'(core_stall), 16'd0);
    chk($sformatf("%s_ack", tag), 16'(host_ack), 16'd1);
    chk($sformatf("%s_rdata", tag), host_rdata, exp_rd);
    host_req = 1'b0;
    tick();
    chk($sformatf("%s_ack_drop", tag), 16'(host_ack), 16'd0);
  endtask

  initial begin
    reset = 1'b1; core_valid = 1'b1; core_write = 1'b1; core_rsrc = 4'd0; core_rdst = 4'd2;
    core_wdata = 16'h0001; core_pc = 16'h0100; host_req = 1'b0; host_we = 1'b0;
    host_addr = 4'd0; host_wdata = 16'h0;
    tick();
    tick();
    chk("reset_rf_write", 16'(rf_write), 16'd0);
    chk("reset_ack", 16'(host_ack), 16'd0);
    chk("reset_rdata", host_rdata, 16'h0);
    chk("reset_stall", 16'(core_stall), 16'd0);
    reset = 1'b0; core_wdata = 16'h0042;
    #1;
    chk("core_write_pass", 16'(rf_write), 16'd1);
    chk("core_wdata_pass", rf_wdata, 16'h0042);
    tick();
    core_valid = 1'b0; core_rsrc = 4'd2;
    #1;
    chk("core_dsrc_pass", core_dsrc, 16'h0042);
    host_op(1'b1, 4'd3, 16'hBEEF, 2, 16'hBEEF, "t1_wr_r3");
    host_op(1'b0, 4'd3, 16'h0000, 2, 16'hBEEF, "t1_rd_r3");
    core_rsrc = 4'd3;
    #1;
    chk("core_dsrc_r3", core_dsrc, 16'hBEEF);
    host_op(1'b1, 4'd15, 16'h1234, 2, 16'h1234, "t2_wr_r15");
    host_op(1'b0, 4'd15, 16'h0000, 2, 16'h1234, "t2_rd_r15");
    host_op(1'b1, 4'd0, 16'hFFFF, 2, 16'h0000, "t3_wr_r0");
    host_op(1'b0, 4'd0, 16'h0000, 2, 16'h0000, "t3_rd_r0");
    core_valid = 1'b1; core_write = 1'b1; core_rdst = 4'd5; core_wdata = 16'hAAAA;
    host_op(1'b0, 4'd5, 16'h0000, 9, 16'hAAAA, "t4_starve");
    core_valid = 1'b0; core_write = 1'b0;
    host_op(1'b0, 4'd5, 16'h0000, 2, 16'hAAAA, "t5_rd_r5");
    host_op(1'b1, 4'd4, 16'h1111, 2, 16'h1111, "t6_pre_r4");
    host_we = 1'b1; host_addr = 4'd4; host_wdata = 16'h5555; host_req = 1'b1;
    tick();
    tick();
    chk("t6_access_stall", 16'(core_stall), 16'd1);
    reset = 1'b1;
    #1;
    chk("t6_reset_no_write", 16'(rf_write), 16'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_reset_ack", 16'(host_ack), 16'd0);
    chk("t6_reset_idle", 16'(core_stall), 16'd0);
    chk("t6_r4_kept", regs[4], 16'h1111);
    tick();
    chk("t6_restart_wait", 16'(core_stall), 16'd0);
    tick();
    chk("t6_restart_access", 16'(core_stall), 16'd1);
    chk("t6_restart_write", 16'(rf_write), 16'd1);
    chk("t6_restart_wdata", rf_wdata, 16'h5555);
    tick();
    chk("t6_restart_ack", 16'(host_ack), 16'd1);
    chk("t6_restart_rdata", host_rdata, 16'h5555);
    host_req = 1'b0;
    tick();
    chk("t6_ack_drop", 16'(host_ack), 16'd0);
    chk("t6_r4_new", regs[4], 16'h5555);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
